button_ctrl: RTL and testbench

Input-conditioning stage that sits directly upstream of the LED pattern controller. It turns the two raw push-buttons into clean control levels. Each button is synchronized, debounced on a slow sample tick and edge-detected by a small FSM. The `en_o` and `dir_o` outputs toggle on each press and drive the pattern controller's `en` and `dir` inputs.

---
 rtl/button_ctrl_if.sv | 29 ++
 rtl/button_ctrl.sv | 141 ++++++++++++++
 tb/tb_button_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_ctrl_if.sv
// button_ctrl_if: raw buttons in, conditioned control levels and pulses out.
// master = the side that owns the buttons and uses the outputs.
// slave  = the button_ctrl block.
interface button_ctrl_if;
    logic btn_en;
    logic btn_dir;
    logic en_o;
    logic dir_o;
    logic en_pulse;
    logic dir_pulse;

    modport master (
        output btn_en,
        output btn_dir,
        input  en_o,
        input  dir_o,
        input  en_pulse,
        input  dir_pulse
    );

    modport slave (
        input  btn_en,
        input  btn_dir,
        output en_o,
        output dir_o,
        output en_pulse,
        output dir_pulse
    );
endinterface

// File: rtl/button_ctrl.sv
// button_ctrl: conditions two raw push-buttons into clean toggle levels.
// Each button is synchronized by two flops, debounced on a slow sample tick
// (DB_LEN equal samples required to change level) and edge-detected by a
// two-state FSM that emits one pulse per press. en_o / dir_o invert on the
// same edge that registers the matching pulse.
//
// Optional feature, macro BUTTON_CTRL_DIR_LOCK_EN: when defined, dir_o only
// toggles while en_o is 0 (value before the edge); dir_pulse is unaffected.
module button_ctrl #(
    parameter int TICK_W = 16,
    parameter int DB_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    button_ctrl_if.slave bus
);

    localparam int NUM_BTN = 2;
    localparam int BTN_EN  = 0;
    localparam int BTN_DIR = 1;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } edge_state_t;

    logic [NUM_BTN-1:0] raw;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] pulse;
    logic               en_level;
    logic               dir_level;
    logic               dir_toggle;

    assign raw = {bus.btn_dir, bus.btn_en};

    // Free-running sample-tick counter; wraps naturally so ticks stay evenly spaced.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = &tick_cnt;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic [1:0]        sync;
        logic [DB_LEN-1:0] shift_q;
        logic [DB_LEN-1:0] shift_d;
        logic              db;
        logic              pulse_q;
        edge_state_t       state;

        // Two-flop synchronizer for the asynchronous raw button.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= 2'b00;
            end else begin
                sync <= {sync[0], raw[b]};
            end
        end

        // Contents the shift register will hold after this tick; the level
        // decision is made on these new contents, not the old ones.
        assign shift_d = {shift_q[DB_LEN-2:0], sync[1]};

        // Debounce: shift and re-evaluate the level only on tick edges.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q <= '0;
                db      <= 1'b0;
            end else if (tick) begin
                shift_q <= shift_d;
                if (&shift_d) begin
                    db <= 1'b1;
                end else if (~|shift_d) begin
                    db <= 1'b0;
                end
            end
        end

        // A press is the IDLE->HELD transition; shared with the toggle logic so
        // the level change lands on the same edge as the pulse.
        assign press[b] = (state == IDLE) && db;

        // Edge FSM with registered pulse output.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (db) begin
                            state   <= HELD;
                            pulse_q <= 1'b1;
                        end
                    end
                    HELD: begin
                        if (!db) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign pulse[b] = pulse_q;
    end

`ifdef BUTTON_CTRL_DIR_LOCK_EN
    // Direction is frozen while enabled; en_level here is the pre-edge value,
    // so a dir press coinciding with the enable turning on still toggles.
    assign dir_toggle = press[BTN_DIR] && !en_level;
`else
    assign dir_toggle = press[BTN_DIR];
`endif

    // Toggle levels, inverted on the edge that registers the matching pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_level  <= 1'b0;
            dir_level <= 1'b0;
        end else begin
            en_level  <= en_level ^ press[BTN_EN];
            dir_level <= dir_level ^ dir_toggle;
        end
    end

    assign bus.en_o      = en_level;
    assign bus.dir_o     = dir_level;
    assign bus.en_pulse  = pulse[BTN_EN];
    assign bus.dir_pulse = pulse[BTN_DIR];

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed scenarios plus randomized button activity.
// A reference model counts consecutive tick samples per button and predicts
// each press pulse and resulting level; predictions go into a queue that a
// separate monitor drains and compares against the DUT every cycle.
module tb_button_ctrl;

    localparam int TICK_W      = 2;
    localparam int DB_LEN      = 3;
    localparam int TICK_PERIOD = 1 << TICK_W;
    localparam int HALF        = 5;

    typedef struct {
        longint t;
        bit     is_dir;
        bit     level;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    button_ctrl_if bus ();

    button_ctrl #(
        .TICK_W(TICK_W),
        .DB_LEN(DB_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #HALF clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned edge_no = 0;
    bit   hist1   [2] = '{0, 0};
    bit   hist2   [2] = '{0, 0};
    bit   run_val [2] = '{0, 0};
    int   run_len [2] = '{DB_LEN, DB_LEN};
    bit   db      [2] = '{0, 0};
    bit   db_seen [2] = '{0, 0};
    bit   raw_s   [2];
    bit   rise    [2];
    bit   m_en  = 0;
    bit   m_dir = 0;
    bit   en_before;
    exp_t ent;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_no = 0;
            m_en    = 0;
            m_dir   = 0;
            exp_q.delete();
            for (int b = 0; b < 2; b++) begin
                hist1[b]   = 0;
                hist2[b]   = 0;
                run_val[b] = 0;
                run_len[b] = DB_LEN;
                db[b]      = 0;
                db_seen[b] = 0;
            end
        end else begin
            edge_no++;
            raw_s[0] = bus.btn_en;
            raw_s[1] = bus.btn_dir;
            // A debounced level that went high on the previous edge is a press now.
            for (int b = 0; b < 2; b++) begin
                rise[b]    = db[b] && !db_seen[b];
                db_seen[b] = db[b];
            end
            en_before = m_en;
            if (rise[0]) begin
                m_en = !m_en;
                ent  = '{t: longint'($time), is_dir: 1'b0, level: m_en};
                exp_q.push_back(ent);
            end
            if (rise[1]) begin
`ifdef BUTTON_CTRL_DIR_LOCK_EN
                if (!en_before) m_dir = !m_dir;
`else
                m_dir = !m_dir;
`endif
                ent = '{t: longint'($time), is_dir: 1'b1, level: m_dir};
                exp_q.push_back(ent);
            end
            // Tick edges sample the raw value seen two edges earlier.
            if ((edge_no - 1) % TICK_PERIOD == TICK_PERIOD - 1) begin
                for (int b = 0; b < 2; b++) begin
                    if (hist2[b] == run_val[b]) begin
                        if (run_len[b] < DB_LEN) run_len[b]++;
                    end else begin
                        run_val[b] = hist2[b];
                        run_len[b] = 1;
                    end
                    if (run_len[b] >= DB_LEN) db[b] = run_val[b];
                end
            end
            for (int b = 0; b < 2; b++) begin
                hist2[b] = hist1[b];
                hist1[b] = raw_s[b];
            end
        end
    end

    // ---------------- monitor ----------------
    bit   ep, dp, el, dl;
    exp_t got;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_en_o", bus.en_o, 0);
            check("rst_dir_o", bus.dir_o, 0);
            check("rst_en_pulse", bus.en_pulse, 0);
            check("rst_dir_pulse", bus.dir_pulse, 0);
        end else begin
            ep = 0; dp = 0; el = 0; dl = 0;
            while (exp_q.size() > 0 && exp_q[0].t <= longint'($time) - HALF) begin
                got = exp_q.pop_front();
                if (got.t == longint'($time) - HALF) begin
                    if (got.is_dir) begin
                        dp = 1; dl = got.level;
                    end else begin
                        ep = 1; el = got.level;
                    end
                end
            end
            check("en_pulse", bus.en_pulse, ep);
            check("dir_pulse", bus.dir_pulse, dp);
            if (ep) check("en_o_with_pulse", bus.en_o, el);
            if (dp) check("dir_o_with_pulse", bus.dir_o, dl);
            check("en_o", bus.en_o, m_en);
            check("dir_o", bus.dir_o, m_dir);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit en, input bit dir, input int n);
        bus.btn_en  = en;
        bus.btn_dir = dir;
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse(input int delay, input int cycles);
        @(posedge clk);
        #(delay);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.btn_en  = 1'b1;
        bus.btn_dir = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        // Buttons held through reset: one press each after release.
        drive(1, 1, 30);
        drive(0, 0, 30);

        // Clean presses.
        drive(1, 0, 40);
        drive(0, 0, 40);
        drive(1, 0, 40);
        drive(0, 0, 40);

        // Bounce every cycle, then bounce at the tick rate.
        for (int i = 0; i < 32; i++) drive(i[0], 0, 1);
        drive(0, 0, 40);
        for (int i = 0; i < 8; i++) drive(i[0], 0, TICK_PERIOD);
        drive(0, 0, 40);

        // Long hold.
        drive(0, 1, 1000);
        drive(0, 0, 40);

        // Direction press while enabled.
        if (!m_en) begin
            drive(1, 0, 30);
            drive(0, 0, 30);
        end
        drive(0, 1, 30);
        drive(0, 0, 30);

        // Simultaneous presses.
        drive(1, 1, 30);
        drive(0, 0, 30);
        drive(1, 1, 30);
        drive(0, 0, 30);

        // Reset while held.
        drive(1, 0, 30);
        reset_pulse(2, 2);
        drive(1, 0, 30);
        drive(0, 0, 30);

        // Randomized activity with occasional resets.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(1, 16)));
        end

        drive(0, 0, 60);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
